uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command-frame controller between the UART receiver, the register file and the UART transmitter.
- Consumes validated RX bytes and decodes write and read command frames.
- Drives single-cycle register-file accesses.
- Hands read-back data to the TX path over a valid/ready handshake.
- Flags malformed, overrun and timed-out frames.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and register-file data
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
TIMEOUT_CYCLES, 4096, max clk cycles allowed between frame bytes, or waiting for rf_rd_valid, before abort (must be >= 2)
OPC_WR, 8'hAA, write opcode
OPC_RD, 8'hBB, read opcode

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
rx_data  input  DATA_WIDTH  received byte, valid while rx_valid is high
rx_valid  input  1  one-cycle pulse per received byte
rf_addr  output  ADDR_WIDTH  register-file address (registered)
rf_wr_en  output  1  one-cycle write strobe
rf_wr_data  output  DATA_WIDTH  write data (registered)
rf_rd_en  output  1  one-cycle read strobe
rf_rd_data  input  DATA_WIDTH  read data, valid with rf_rd_valid
rf_rd_valid  input  1  one-cycle read-data-valid pulse
tx_data  output  DATA_WIDTH  byte offered to TX
tx_valid  output  1  TX request; held until accepted
tx_ready  input  1  TX can accept; transfer when tx_valid & tx_ready
busy  output  1  high in every state except IDLE
frame_err  output  1  one-cycle pulse on any frame abort or dropped byte

Behaviour:
- Reset (async, reset_n low): state=IDLE, all outputs 0, timeout counter 0, addr/data holding registers 0. Reset mid-frame discards the frame; no rf or tx strobe is issued afterwards.
- All outputs are registered. A decision made on cycle N is visible on N+1.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - rx_valid & rx_data==OPC_WR -> WR_ADDR.
  - rx_valid & rx_data==OPC_RD -> RD_ADDR.
  - rx_valid with any other byte -> stay IDLE, frame_err pulse.
- Address byte (WR_ADDR/RD_ADDR, on rx_valid):
  - If rx_data[DATA_WIDTH-1:ADDR_WIDTH] != 0 -> frame_err pulse, IDLE.
  - Otherwise latch the low ADDR_WIDTH bits into rf_addr. WR_ADDR -> WR_DATA. RD_ADDR -> RD_WAIT with rf_rd_en=1 for exactly one cycle.
- WR_DATA: rx_valid at cycle N -> rf_wr_data=rx_data and rf_wr_en=1 on N+1 only; state -> IDLE.
- RD_WAIT:
  - rf_rd_valid at cycle M -> tx_data=rf_rd_data and tx_valid=1 from M+1; state -> TX_SEND.
  - rf_rd_valid in any other state is ignored.
- TX_SEND: tx_valid and tx_data stay stable until a cycle with tx_ready=1. That cycle is the transfer; tx_valid=0 the next cycle; state -> IDLE.
- Timeout counter:
  - Cleared on every state change and on each accepted rx byte.
  - Increments each cycle in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulse, IDLE, no strobe issued. No timeout in TX_SEND.
- Overrun: rx_valid while in RD_WAIT or TX_SEND -> byte dropped, frame_err pulse, state unchanged.
- Simultaneous events:
  - rx_valid and timeout expiry in the same cycle: the byte is processed and the timeout is ignored.
  - rf_rd_valid and rx_valid in RD_WAIT: read data is captured and frame_err pulses.
- Back-to-back: IDLE accepts a new opcode on the cycle immediately after a completed frame. rf_wr_en is never asserted in consecutive cycles.
- frame_err is never high for more than one cycle per event; rf_wr_en and rf_rd_en are never high together.

Test Plan:
- Write frame: AA, 05, 3C as rx_valid pulses spaced 10 cycles -> rf_wr_en high 1 cycle after the 3C pulse with rf_addr=5 and rf_wr_data=3C; busy low afterwards; no frame_err.
- Read frame: BB, 07; model returns rf_rd_valid with 5A 2 cycles after rf_rd_en; tx_ready held low 6 cycles then high -> rf_rd_en pulses once with rf_addr=7; tx_valid stays high with tx_data=5A until the tx_ready cycle, then drops.
- Bad opcode and bad address: byte 12 in IDLE -> frame_err pulse, stays IDLE. Frame AA, 35 -> frame_err, IDLE, no rf_wr_en.
- Timeout with TIMEOUT_CYCLES=16: send AA, then no bytes -> frame_err exactly 15 cycles after the AA-accept cycle; then AA, 01, FF completes normally.
- Overrun: rx byte 77 arrives in TX_SEND -> frame_err pulse; tx_data unchanged; transfer completes.
- Reset mid-frame: after AA, 03, assert reset_n low 2 cycles, then send FF -> no rf_wr_en, frame_err pulse (FF is an unknown opcode in IDLE).

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command-frame controller between UART RX, the register file and UART TX.
// Decodes write frames (OPC_WR, addr, data) and read frames (OPC_RD, addr). It issues
// single-cycle register-file strobes and returns read data to TX over valid/ready.
// Malformed, overrun and timed-out frames are flagged on frame_err.
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   rx_data, rx_valid    received byte and its one-cycle valid pulse
//   rf_addr              registered register-file address
//   rf_wr_en, rf_wr_data one-cycle write strobe and registered write data
//   rf_rd_en             one-cycle read strobe
//   rf_rd_data/valid     read data returned by the register file
//   tx_data, tx_valid    byte offered to TX, held until tx_ready
//   tx_ready             TX accepts when tx_valid & tx_ready
//   busy                 high whenever a frame is in progress
//   frame_err            one-cycle pulse per abort or dropped byte
module uart_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [DATA_WIDTH-1:0] OPC_WR = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] OPC_RD = 8'hBB
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_wr_en,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES) + 1;
    // cnt_q counts cycles elapsed since the last clear event, so the clear cycle itself is
    // cycle 0. Deciding at TIMEOUT_CYCLES-2 makes frame_err appear on cycle TIMEOUT_CYCLES-1.
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StTxSend
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  timed_out;
    logic                  addr_bad;

    assign timed_out = (cnt_q >= CntLimit);
    assign addr_bad  = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] != '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == OPC_WR)      state_d = StWrAddr;
                    else if (rx_data == OPC_RD) state_d = StRdAddr;
                    else                        frame_err_d = 1'b1;
                end
            end
            StWrAddr, StRdAddr: begin
                // An arriving byte takes priority over a simultaneous timeout.
                if (rx_valid) begin
                    if (addr_bad) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        rf_addr_d = rx_data[ADDR_WIDTH-1:0];
                        if (state_q == StWrAddr) begin
                            state_d = StWrData;
                        end else begin
                            state_d    = StRdWait;
                            rf_rd_en_d = 1'b1;
                        end
                    end
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWrData: begin
                if (rx_valid) begin
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = StIdle;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StRdWait: begin
                // Any byte here is an overrun and is dropped.
                if (rx_valid) frame_err_d = 1'b1;
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = StTxSend;
                end else if (timed_out && !rx_valid) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StTxSend: begin
                if (rx_valid) frame_err_d = 1'b1;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every accepted byte in a waiting state changes state, so a state change covers
        // both clear conditions.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {StWrAddr, StWrData, StRdAddr, StRdWait}) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Entering a waiting state starts at elapsed cycle 1.
            cnt_q        <= (state_d != state_q) ? CntWidth'(1) : cnt_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rf_addr    = rf_addr_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl (TIMEOUT_CYCLES = 16). A negedge monitor logs
// register-file writes, reads and TX transfers; each test pushes its expected results
// into queues and compares them against the logs.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [3:0] rf_addr;
    logic       rf_wr_en;
    logic [7:0] rf_wr_data;
    logic       rf_rd_en;
    logic [7:0] rf_rd_data = '0;
    logic       rf_rd_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       frame_err;

    uart_cmd_ctrl #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(16),
        .OPC_WR        (8'hAA),
        .OPC_RD        (8'hBB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rf_addr    (rf_addr),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_data (rf_wr_data),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_data (rf_rd_data),
        .rf_rd_valid(rf_rd_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Scoreboard: expected entries pushed by tests, observed entries logged by the monitor.
    logic [11:0] exp_wr[$];
    logic [11:0] wr_log[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic [3:0]  rd_log[$];
    int          consec_wr = 0;
    int          both_en = 0;
    int          tx_unstable = 0;
    logic        prev_wr = 1'b0;
    logic        prev_pending = 1'b0;
    logic [7:0]  prev_tx_data = '0;
    logic [7:0]  rd_value = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rf_wr_en) wr_log.push_back({rf_addr, rf_wr_data});
            if (rf_wr_en && prev_wr) consec_wr++;
            if (rf_wr_en && rf_rd_en) both_en++;
            if (rf_rd_en) rd_log.push_back(rf_addr);
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (prev_pending && (!tx_valid || tx_data !== prev_tx_data)) tx_unstable++;
            prev_wr      = rf_wr_en;
            prev_pending = tx_valid && !tx_ready;
            prev_tx_data = tx_data;
        end else begin
            prev_wr      = 1'b0;
            prev_pending = 1'b0;
        end
    end

    // Register-file read model: data returns two cycles after the read strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && rf_rd_en) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                rf_rd_valid = 1'b1;
                rf_rd_data  = rd_value;
                @(posedge clk); #1;
                rf_rd_valid = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Returns just after the sampling edge, i.e. in the cycle where the decision is visible.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_valid, frame_err} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_valid, frame_err});
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else passed++;
    endtask

    task automatic test_write;
        logic [11:0] e, g;
        exp_wr.push_back({4'h5, 8'h3C});
        send_byte(8'hAA);
        checks++;
        if (busy !== 1'b1) $display("FAIL wr_busy: got %b required 1", busy); else passed++;
        idle(9);
        send_byte(8'h05);
        idle(9);
        send_byte(8'h3C);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data, frame_err} !== {1'b1, 4'h5, 8'h3C, 1'b0})
            $display("FAIL wr_strobe: got %b/%h/%h err %b required 1/5/3c err 0",
                     rf_wr_en, rf_addr, rf_wr_data, frame_err);
        else passed++;
        idle(1);
        checks++;
        if ({rf_wr_en, busy} !== 2'b00)
            $display("FAIL wr_after: got wr_en/busy %b required 00", {rf_wr_en, busy});
        else passed++;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 12'hxxx;
            checks++;
            if (g !== e) $display("FAIL wr_scoreboard: got %h required %h", g, e); else passed++;
        end
    endtask

    task automatic test_read;
        logic [7:0] g;
        rd_value = 8'h5A;
        tx_ready = 1'b0;
        rd_log.delete();
        exp_tx.push_back(8'h5A);
        send_byte(8'hBB);
        send_byte(8'h07);
        checks++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'h7})
            $display("FAIL rd_strobe: got %b/%h required 1/7", rf_rd_en, rf_addr);
        else passed++;
        idle(3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({tx_valid, tx_data} !== {1'b1, 8'h5A})
                $display("FAIL rd_tx_hold: cycle %0d got %b/%h required 1/5a", i, tx_valid,
                         tx_data);
            else passed++;
            if (i < 5) idle(1);
        end
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        checks++;
        if ({tx_valid, busy} !== 2'b00)
            $display("FAIL rd_tx_drop: got valid/busy %b required 00", {tx_valid, busy});
        else passed++;
        checks++;
        if (rd_log.size() !== 1 || rd_log[0] !== 4'h7)
            $display("FAIL rd_count: got %0d strobes required 1 at addr 7", rd_log.size());
        else passed++;
        g = (tx_log.size() > 0) ? tx_log.pop_front() : 8'hxx;
        checks++;
        if (g !== exp_tx.pop_front()) $display("FAIL rd_tx_data: got %h required 5a", g);
        else passed++;
    endtask

    task automatic test_bad;
        send_byte(8'h12);
        checks++;
        if ({frame_err, busy} !== 2'b10)
            $display("FAIL bad_opc: got err/busy %b required 10", {frame_err, busy});
        else passed++;
        idle(1);
        checks++;
        if (frame_err !== 1'b0) $display("FAIL bad_opc_pulse: got %b required 0", frame_err);
        else passed++;
        send_byte(8'hAA);
        send_byte(8'h35);
        checks++;
        if ({frame_err, busy, rf_wr_en} !== 3'b100)
            $display("FAIL bad_addr: got err/busy/wr %b required 100",
                     {frame_err, busy, rf_wr_en});
        else passed++;
        idle(3);
        checks++;
        if (wr_log.size() !== 0) $display("FAIL bad_addr_nowr: got %0d writes required 0",
                                          wr_log.size());
        else passed++;
    endtask

    task automatic test_timeout;
        int first;
        logic [11:0] e, g;
        first = -1;
        send_byte(8'hAA);
        // Now in cycle N+1 relative to the AA-accept cycle N.
        for (int k = 2; k <= 30 && first < 0; k++) begin
            idle(1);
            if (frame_err === 1'b1) first = k;
        end
        checks++;
        if (first !== 15) $display("FAIL timeout_cycle: got %0d required 15", first);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL timeout_idle: got busy %b required 0", busy);
        else passed++;
        exp_wr.push_back({4'h1, 8'hFF});
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        idle(1);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 12'hxxx;
            checks++;
            if (g !== e) $display("FAIL timeout_recover: got %h required %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_overrun;
        logic [7:0] g;
        rd_value = 8'hC3;
        exp_tx.push_back(8'hC3);
        send_byte(8'hBB);
        send_byte(8'h02);
        idle(3);
        send_byte(8'h77);
        checks++;
        if ({frame_err, tx_valid, tx_data, busy} !== {1'b1, 1'b1, 8'hC3, 1'b1})
            $display("FAIL overrun: got err/valid/data/busy %b/%b/%h/%b required 1/1/c3/1",
                     frame_err, tx_valid, tx_data, busy);
        else passed++;
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) $display("FAIL overrun_done: got %b required 0", tx_valid);
        else passed++;
        g = (tx_log.size() > 0) ? tx_log.pop_front() : 8'hxx;
        checks++;
        if (g !== exp_tx.pop_front()) $display("FAIL overrun_tx: got %h required c3", g);
        else passed++;
    endtask

    task automatic test_reset_mid;
        send_byte(8'hAA);
        send_byte(8'h03);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, rf_addr} !== 5'h00)
            $display("FAIL reset_mid_async: got busy/addr %h required 0", {busy, rf_addr});
        else passed++;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send_byte(8'hFF);
        checks++;
        if ({frame_err, rf_wr_en, busy} !== 3'b100)
            $display("FAIL reset_mid: got err/wr/busy %b required 100",
                     {frame_err, rf_wr_en, busy});
        else passed++;
        idle(2);
        checks++;
        if (wr_log.size() !== 0) $display("FAIL reset_mid_nowr: got %0d writes required 0",
                                          wr_log.size());
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [11:0] e, g;
        exp_wr.push_back({4'h1, 8'h11});
        exp_wr.push_back({4'h2, 8'h22});
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h22);
        idle(2);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 12'hxxx;
            checks++;
            if (g !== e) $display("FAIL b2b_write: got %h required %h", g, e); else passed++;
        end
        checks++;
        if (wr_log.size() !== 0) $display("FAIL b2b_extra: got %0d extra writes required 0",
                                          wr_log.size());
        else passed++;
    endtask

    initial begin
        idle(3);
        test_reset;
        reset_n = 1'b1;
        idle(2);
        test_write;
        test_read;
        test_bad;
        test_timeout;
        test_overrun;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (consec_wr !== 0) $display("FAIL wr_consecutive: got %0d required 0", consec_wr);
        else passed++;
        checks++;
        if (both_en !== 0) $display("FAIL wr_rd_overlap: got %0d required 0", both_en);
        else passed++;
        checks++;
        if (tx_unstable !== 0) $display("FAIL tx_stable: got %0d required 0", tx_unstable);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
